// File: rtl/simon_playback_seq_if.sv
// Signal bundle between the Simon playback sequencer, the game FSM, the sequence RAM and the LED driver.
// The sequencer takes the slave view; the game side / bench takes the master view.
interface simon_playback_seq_if #(
  parameter int ADDR_W = 5
);
  logic              tick;
  logic              start;
  logic              abort;
  logic [ADDR_W:0]   length;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data;
  logic [3:0]        led;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] step_idx;

  modport slave (
    input  tick, start, abort, length, mem_data,
    output mem_rd, mem_addr, led, busy, done, step_idx
  );

  modport master (
    output tick, start, abort, length, mem_data,
    input  mem_rd, mem_addr, led, busy, done, step_idx
  );
endinterface

// File: rtl/simon_playback_seq.sv
// Simon round playback: fetches each stored colour, lights its LED for ON_TICKS slow ticks,
// then blanks for OFF_TICKS, after an initial LEAD_TICKS blank period.
module simon_playback_seq #(
  parameter int ADDR_W     = 5,
  parameter int LEAD_TICKS = 2,
  parameter int ON_TICKS   = 4,
  parameter int OFF_TICKS  = 2
) (
  input logic               clk,
  input logic               reset,
  simon_playback_seq_if.slave bus
);

  localparam int MAX_TICKS = (LEAD_TICKS > ON_TICKS) ?
                             ((LEAD_TICKS > OFF_TICKS) ? LEAD_TICKS : OFF_TICKS) :
                             ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
  localparam int CNT_W = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_TICKS - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_TICKS - 1);
  localparam logic [ADDR_W:0]  MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_FETCH,
    S_LATCH,
    S_ON,
    S_OFF,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        led_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              last_entry;

  assign last_entry = ({1'b0, idx} == (len_q - (ADDR_W + 1)'(1)));

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.step_idx = idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      idx        <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      // Abort pre-empts every other event, including a completion about to pulse done.
      if (bus.abort && state != S_IDLE) begin
        state    <= S_IDLE;
        cnt      <= '0;
        led_q    <= '0;
        busy_q   <= 1'b0;
        mem_rd_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start && !bus.abort) begin
              len_q  <= (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
              idx    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= (bus.length == '0) ? S_DONE : S_LEAD;
            end
          end
          S_LEAD: begin
            if (bus.tick) begin
              if (cnt == LEAD_LAST) begin
                cnt        <= '0;
                mem_rd_q   <= 1'b1;
                mem_addr_q <= idx;
                state      <= S_FETCH;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          S_FETCH: begin
            mem_rd_q <= 1'b0;
            state    <= S_LATCH;
          end
          // RAM data is valid one cycle after the strobe, so the colour is captured here.
          S_LATCH: begin
            led_q <= 4'b0001 << bus.mem_data;
            cnt   <= '0;
            state <= S_ON;
          end
          S_ON: begin
            if (bus.tick) begin
              if (cnt == ON_LAST) begin
                cnt   <= '0;
                led_q <= '0;
                state <= S_OFF;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          S_OFF: begin
            if (bus.tick) begin
              if (cnt == OFF_LAST) begin
                cnt <= '0;
                if (last_entry) begin
                  state <= S_DONE;
                end else begin
                  idx        <= idx + ADDR_W'(1);
                  mem_rd_q   <= 1'b1;
                  mem_addr_q <= idx + ADDR_W'(1);
                  state      <= S_FETCH;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          S_DONE: begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  a_led_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(led_q));
  a_rd_in_fetch: assert property (@(posedge clk) disable iff (reset) mem_rd_q |-> (state == S_FETCH));

endmodule
